// File: rtl/wb_initiator.sv
// Wishbone classic single-access initiator. Takes one read/write command at a
// time, runs one bus cycle for it (with retry and timeout handling) and hands
// the read data and completion status back on a valid/ready response port.
module wb_initiator #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst_n,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_adr,
    input  logic [DATA_WIDTH-1:0] cmd_dat,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_dat,
    output logic [1:0]            rsp_status,
    output logic                  busy,
    // Wishbone initiator side
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_we_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic [2:0]            wb_cti_o,
    output logic [1:0]            wb_bte_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i
);

    // A disabled timeout (or zero retries) still needs a 1-bit counter.
    localparam int TMO_W = (TIMEOUT   > 0) ? $clog2(TIMEOUT + 1)   : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_ERR       = 2'b01;
    localparam logic [1:0] ST_TIMEOUT   = 2'b10;
    localparam logic [1:0] ST_RETRY_EXH = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  we_q, we_d;
    logic                  cyc_q, cyc_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]            rsp_status_q, rsp_status_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [RTY_W-1:0]      rty_cnt_q, rty_cnt_d;

    // Next-state and next-output decode for the four-state cycle controller.
    always_comb begin
        // NOTE: every _d takes its held value first so no path leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        we_d         = we_q;
        cyc_d        = cyc_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        rsp_valid_d  = rsp_valid_q;
        tmo_cnt_d    = tmo_cnt_q;
        rty_cnt_d    = rty_cnt_q;

        unique case (state_q)
            IDLE: begin
                // cmd_ready is high whenever the flops are out of reset here.
                if (cmd_valid) begin
                    adr_d     = cmd_adr;
                    dat_d     = cmd_dat;
                    we_d      = cmd_we;
                    cyc_d     = 1'b1;
                    tmo_cnt_d = '0;
                    rty_cnt_d = '0;
                    state_d   = BUS;
                end
            end

            BUS: begin
                if (wb_ack_i) begin
                    rsp_dat_d    = we_q ? '0 : wb_dat_i;
                    rsp_status_d = ST_OK;
                    rsp_valid_d  = 1'b1;
                    cyc_d        = 1'b0;
                    state_d      = RESP;
                end else if (wb_err_i) begin
                    rsp_dat_d    = '0;
                    rsp_status_d = ST_ERR;
                    rsp_valid_d  = 1'b1;
                    cyc_d        = 1'b0;
                    state_d      = RESP;
                end else if (wb_rty_i) begin
                    cyc_d = 1'b0;
                    if (rty_cnt_q == RTY_LIMIT) begin
                        rsp_dat_d    = '0;
                        rsp_status_d = ST_RETRY_EXH;
                        rsp_valid_d  = 1'b1;
                        state_d      = RESP;
                    end else begin
                        rty_cnt_d = rty_cnt_q + 1'b1;
                        state_d   = GAP;
                    end
                end else if ((TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) begin
                    rsp_dat_d    = '0;
                    rsp_status_d = ST_TIMEOUT;
                    rsp_valid_d  = 1'b1;
                    cyc_d        = 1'b0;
                    state_d      = RESP;
                end else if (tmo_cnt_q != '1) begin
                    // Saturates instead of wrapping when the timeout is disabled.
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            GAP: begin
                // One idle cycle, then re-issue the same access.
                tmo_cnt_d = '0;
                cyc_d     = 1'b1;
                state_d   = BUS;
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops cyc/stb without waiting for a clock.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q      <= IDLE;
            adr_q        <= '0;
            dat_q        <= '0;
            we_q         <= 1'b0;
            cyc_q        <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_OK;
            rsp_valid_q  <= 1'b0;
            tmo_cnt_q    <= '0;
            rty_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q      <= state_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            we_q         <= we_d;
            cyc_q        <= cyc_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            rsp_valid_q  <= rsp_valid_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rty_cnt_q    <= rty_cnt_d;
        end
    end

    // cmd_ready and busy decode the state; cmd_ready is also held low in reset.
    assign cmd_ready  = (state_q == IDLE) && wb_rst_n;
    assign busy       = (state_q != IDLE);

    assign rsp_valid  = rsp_valid_q;
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = rsp_status_q;

    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_we_o    = we_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_cti_o   = 3'b000;
    assign wb_bte_o   = 2'b00;

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: a scripted Wishbone slave, a bus
// monitor, a directed vector table and randomized transactions checked against
// an outcome model derived from the termination/retry/timeout rules.
module tb_wb_initiator;

    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int TMO  = 8;
    localparam int MAXR = 3;

    typedef enum int {F_ACK, F_ERR, F_ERRACK, F_NONE} fin_e;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [DW-1:0] rdata;   // slave read data on the final ack
        int            w;       // wait states before each termination
        int            r;       // number of rty answers before the final one
        fin_e          fin;     // final termination kind
        int            hold;    // extra cycles rsp_ready stays low
        logic [1:0]    exp_st;
        logic [DW-1:0] exp_dat;
        int            exp_stb; // total stb-high cycles
        int            exp_att; // number of bus attempts
    } vec_t;

    logic          wb_clk = 1'b0;
    logic          wb_rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic          rsp_ready = 1'b0;
    logic          cmd_ready, rsp_valid, busy;
    logic [DW-1:0] rsp_dat;
    logic [1:0]    rsp_status;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic          wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic [DW-1:0] wb_dat_i = '0;
    logic          wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

    int errors = 0;
    int checks = 0;

    wb_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_status(rsp_status), .busy(busy),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o),
        .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scripted slave ----------------
    int            s_w = 0, s_r = 0, s_cnt = 0, s_att = 0;
    fin_e          s_fin = F_ACK;
    logic [DW-1:0] s_rdata = '0;

    always @(negedge wb_clk) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        wb_dat_i = DW'($urandom);
        if (wb_stb_o) begin
            s_cnt++;
            if (s_cnt == s_w + 1) begin
                if (s_att < s_r) wb_rty_i = 1'b1;
                else begin
                    case (s_fin)
                        F_ACK:    begin wb_ack_i = 1'b1; wb_dat_i = s_rdata; end
                        F_ERR:    wb_err_i = 1'b1;
                        F_ERRACK: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = s_rdata; end
                        default:  ;
                    endcase
                end
            end
        end else begin
            if (s_cnt != 0) s_att++;
            s_cnt = 0;
        end
    end

    // ---------------- bus monitor ----------------
    logic [AW-1:0] cur_adr = '0;
    logic [DW-1:0] cur_dat = '0;
    logic          cur_we = 1'b0;
    int  attempts = 0, stb_cycles = 0, low_run = 0;
    bit  prev_stb = 1'b0, bus_bad = 1'b0, gap_bad = 1'b0;

    always @(negedge wb_clk) begin
        if (wb_cyc_o !== wb_stb_o || wb_cti_o !== 3'b000 || wb_bte_o !== 2'b00) bus_bad = 1'b1;
        if (wb_stb_o) begin
            if (wb_adr_o !== cur_adr || wb_we_o !== cur_we || (cur_we && wb_dat_o !== cur_dat))
                bus_bad = 1'b1;
            if (!prev_stb) begin
                attempts++;
                if (attempts > 1 && low_run != 1) gap_bad = 1'b1;
            end
            stb_cycles++;
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_stb = wb_stb_o;
    end

    // Outcome model: what the rules say must happen for a given slave script.
    task automatic model(input vec_t v, output logic [1:0] st, output logic [DW-1:0] d,
                         output int stb, output int att);
        if (v.w >= TMO) begin
            st = 2'b10; d = '0; att = 1; stb = TMO;
        end else if (v.r > MAXR) begin
            st = 2'b11; d = '0; att = MAXR + 1; stb = att * (v.w + 1);
        end else begin
            att = v.r + 1;
            stb = v.r * (v.w + 1);
            case (v.fin)
                F_ACK, F_ERRACK: begin st = 2'b00; d = v.we ? '0 : v.rdata; stb += v.w + 1; end
                F_ERR:           begin st = 2'b01; d = '0; stb += v.w + 1; end
                default:         begin st = 2'b10; d = '0; stb += TMO; end
            endcase
        end
    endtask

    task automatic setup_slave(input vec_t v);
        s_w = v.w; s_r = v.r; s_fin = v.fin; s_rdata = v.rdata; s_att = 0; s_cnt = 0;
        cur_adr = v.adr; cur_dat = v.dat; cur_we = v.we;
        attempts = 0; stb_cycles = 0; low_run = 0; bus_bad = 1'b0; gap_bad = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input logic [1:0] est, input logic [DW-1:0] edat,
                           input int estb, input int eatt, input string tag);
        int  n;
        bit  got, hold_bad;
        @(negedge wb_clk);
        setup_slave(v);
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge wb_clk); n++; end
        check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat;
        @(posedge wb_clk);
        #1;
        cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = DW'($urandom); cmd_we = ~v.we;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge wb_clk);
            if (rsp_valid) begin got = 1'b1; break; end
        end
        check({tag, " rsp_valid seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, " status"}, 32'(rsp_status), 32'(est));
            check({tag, " rsp_dat"}, 32'(rsp_dat), 32'(edat));
            check({tag, " attempts"}, 32'(attempts), 32'(eatt));
            check({tag, " stb cycles"}, 32'(stb_cycles), 32'(estb));
            check({tag, " bus stable"}, 32'(bus_bad), 32'd0);
            check({tag, " gap 1 cycle"}, 32'(gap_bad), 32'd0);
            hold_bad = 1'b0;
            for (int i = 0; i < v.hold; i++) begin
                @(negedge wb_clk);
                if (!rsp_valid || rsp_status !== est || rsp_dat !== edat || cmd_ready || !busy)
                    hold_bad = 1'b1;
            end
            check({tag, " rsp held"}, 32'(hold_bad), 32'd0);
            rsp_ready = 1'b1;
            @(posedge wb_clk);
            #1;
            rsp_ready = 1'b0;
            @(negedge wb_clk);
            check({tag, " idle after rsp"}, {30'd0, rsp_valid, cmd_ready}, 32'd1);
        end
    endtask

    vec_t tbl[11];

    initial begin
        vec_t          v;
        logic [1:0]    est;
        logic [DW-1:0] edat;
        int            estb, eatt;
        bit            bad;

        //            we    adr     dat    rdata  w  r  fin       hold st     dat    stb att
        tbl[0]  = '{1'b1, 32'h04, 8'hA5, 8'h00, 0, 0, F_ACK,    0, 2'b00, 8'h00, 1,  1};
        tbl[1]  = '{1'b0, 32'h00, 8'h11, 8'h3C, 3, 0, F_ACK,    4, 2'b00, 8'h3C, 4,  1};
        tbl[2]  = '{1'b0, 32'h10, 8'h22, 8'h5A, 0, 2, F_ACK,    0, 2'b00, 8'h5A, 3,  3};
        tbl[3]  = '{1'b1, 32'h20, 8'h77, 8'h00, 0, 9, F_ACK,    1, 2'b11, 8'h00, 4,  4};
        tbl[4]  = '{1'b0, 32'h30, 8'h00, 8'hFF, 0, 0, F_NONE,   0, 2'b10, 8'h00, 8,  1};
        tbl[5]  = '{1'b0, 32'h34, 8'h00, 8'h99, 7, 0, F_ACK,    0, 2'b00, 8'h99, 8,  1};
        tbl[6]  = '{1'b0, 32'h38, 8'h00, 8'hC3, 1, 0, F_ERRACK, 0, 2'b00, 8'hC3, 2,  1};
        tbl[7]  = '{1'b0, 32'h3C, 8'h00, 8'hEE, 2, 0, F_ERR,    2, 2'b01, 8'h00, 3,  1};
        tbl[8]  = '{1'b1, 32'h40, 8'h5F, 8'h00, 0, 0, F_ERR,    0, 2'b01, 8'h00, 1,  1};
        tbl[9]  = '{1'b0, 32'h44, 8'h00, 8'h12, 0, 1, F_NONE,   0, 2'b10, 8'h00, 9,  2};
        tbl[10] = '{1'b0, 32'h48, 8'h00, 8'h6B, 2, 3, F_ACK,    0, 2'b00, 8'h6B, 12, 4};

        // Reset state
        #12;
        check("reset outputs", {wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, cmd_ready, busy,
                                rsp_status}, 32'd0);
        check("reset wb_adr_o", wb_adr_o, 32'd0);
        check("reset dat", {16'd0, wb_dat_o, rsp_dat}, 32'd0);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        @(negedge wb_clk);
        check("cmd_ready after reset", 32'(cmd_ready), 32'd1);

        // Minimum latency: accept @0, stb @1, rsp_valid @2, cmd_ready @3
        setup_slave(tbl[0]);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h04; cmd_dat = 8'hA5;
        @(posedge wb_clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge wb_clk);
        check("lat c1 bus", {wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, cmd_ready, busy}, 32'b111001);
        check("lat c1 adr/dat", {wb_adr_o[23:0], wb_dat_o}, {24'h04, 8'hA5});
        @(negedge wb_clk);
        check("lat c2 rsp", {wb_stb_o, rsp_valid, cmd_ready, rsp_status, rsp_dat}, {3'b010, 2'b00, 8'h00});
        @(negedge wb_clk);
        check("lat c3 ready", {rsp_valid, cmd_ready}, 32'b01);
        rsp_ready = 1'b0;

        // Directed table
        for (int i = 0; i < 11; i++)
            run_txn(tbl[i], tbl[i].exp_st, tbl[i].exp_dat, tbl[i].exp_stb, tbl[i].exp_att,
                    $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a bus cycle
        v = '{1'b0, 32'h50, 8'h00, 8'h00, 0, 0, F_NONE, 0, 2'b00, 8'h00, 0, 0};
        @(negedge wb_clk);
        setup_slave(v);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h50;
        @(posedge wb_clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge wb_clk);
        check("pre-reset stb", 32'(wb_stb_o), 32'd1);
        #2;
        wb_rst_n = 1'b0;
        #1;
        check("async drop cyc/stb", {wb_cyc_o, wb_stb_o, busy, cmd_ready}, 32'd0);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge wb_clk);
            if (rsp_valid || wb_stb_o) bad = 1'b1;
        end
        check("no rsp after reset", 32'(bad), 32'd0);
        check("ready after reset", 32'(cmd_ready), 32'd1);
        run_txn(tbl[1], tbl[1].exp_st, tbl[1].exp_dat, tbl[1].exp_stb, tbl[1].exp_att, "post-reset");

        // Randomized transactions against the outcome model
        for (int i = 0; i < 40; i++) begin
            v.we    = 1'($urandom_range(0, 1));
            v.adr   = $urandom;
            v.dat   = DW'($urandom);
            v.rdata = DW'($urandom);
            v.w     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(7, 9)) : int'($urandom_range(0, 3));
            v.r     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 5)) : int'($urandom_range(0, 2));
            v.fin   = fin_e'($urandom_range(0, 3));
            v.hold  = int'($urandom_range(0, 3));
            model(v, est, edat, estb, eatt);
            run_txn(v, est, edat, estb, eatt, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
